// File: rtl/corelet_seq.sv
// corelet_seq: runs one corelet tile per start (weights -> L0 -> kernel load, activations -> L0 -> execute,
// OFIFO -> PMEM, then an SFP accumulate/ReLU pass when SEQ_SFP_EN is defined); outputs registered, busy one cycle after start.
// Only DRAIN waits: it stalls on ofifo_valid for at most drain_max cycles, then sets sticky err and finishes.
module corelet_seq #(
   parameter int row        = 8,
   parameter int col        = 8,
   parameter int addr_bw    = 11,
   parameter int len_bw     = 8,
   parameter int inst_width = 35,
   parameter int drain_max  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [addr_bw-1:0]    w_base,
   input  logic [addr_bw-1:0]    a_base,
   input  logic [addr_bw-1:0]    p_base,
   input  logic [len_bw-1:0]     len,
   input  logic                  ofifo_valid,
   output logic [inst_width-1:0] inst,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // instruction bus field positions
`ifdef SEQ_SFP_EN
   localparam int SFP_RELU  = 34;
   localparam int SFP_ACC   = 33;
`endif
   localparam int CEN_PMEM  = 32;
   localparam int WEN_PMEM  = 31;
   localparam int A_PMEM_LO = 20;
   localparam int CEN_XMEM  = 19;
   localparam int WEN_XMEM  = 18;
   localparam int A_XMEM_LO = 7;
   localparam int OFIFO_RD  = 6;
   localparam int L0_RD     = 3;
   localparam int L0_WR     = 2;
   localparam int EXEC_BIT  = 1;
   localparam int KLOAD_BIT = 0;

   // both SRAM chip enables deasserted, everything else quiet
   localparam logic [inst_width-1:0] INST_IDLE = inst_width'(35'h1_0008_0000);

   // phase counter must hold col (weight/L0 phases), drain_max and len+1 (fill and SFP phases)
   localparam int PH_MAX = ((col > row) ? col : row) + 1;
   localparam int FIX_W  = $clog2(((PH_MAX > drain_max) ? PH_MAX : drain_max) + 1);
   localparam int CW     = (FIX_W > len_bw + 1) ? FIX_W : len_bw + 1;

   typedef enum logic [3:0] {
      IDLE,
      W_FILL,
      W_LOAD,
      A_FILL,
      EXEC,
      DRAIN,
      O_READ,
`ifdef SEQ_SFP_EN
      SFP,
`endif
      DONE
   } state_t;

   state_t                  state, state_n;
   logic [CW-1:0]           cnt, cnt_n, cnt_inc;
   logic [CW-1:0]           len_qe, len_e;
   logic [addr_bw-1:0]      w_q, a_q, p_q, w_n, a_n, p_n;
   logic [len_bw-1:0]       len_q, len_n;
   logic [inst_width-1:0]   inst_n;
   logic                    busy_n, done_n, err_n;

   // next state/counter, then decode the registered outputs from that next state so they line up with it
   always_comb begin
      state_n = state;
      cnt_n   = '0;
      cnt_inc = cnt + CW'(1);
      err_n   = err;
      w_n     = w_q;
      a_n     = a_q;
      p_n     = p_q;
      len_n   = len_q;
      len_qe  = CW'(len_q);
      len_e   = '0;
      inst_n  = INST_IDLE;
      busy_n  = 1'b1;
      done_n  = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_n = W_FILL;
                  w_n     = w_base;
                  a_n     = a_base;
                  p_n     = p_base;
                  len_n   = len;
                  err_n   = 1'b0;
               end else begin
                  // empty tile: finish without touching SRAM or L0
                  state_n = DONE;
               end
            end
         end
         W_FILL: begin
            if (cnt == CW'(col)) state_n = W_LOAD;
            else                 cnt_n   = cnt_inc;
         end
         W_LOAD: begin
            if (cnt == CW'(col - 1)) state_n = A_FILL;
            else                     cnt_n   = cnt_inc;
         end
         A_FILL: begin
            if (cnt == len_qe) state_n = EXEC;
            else               cnt_n   = cnt_inc;
         end
         EXEC: begin
            if (cnt == len_qe - CW'(1)) state_n = DRAIN;
            else                        cnt_n   = cnt_inc;
         end
         DRAIN: begin
            // data arriving on the last allowed cycle still wins over the timeout
            if (ofifo_valid) begin
               state_n = O_READ;
            end else if (cnt == CW'(drain_max - 1)) begin
               state_n = DONE;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         O_READ: begin
            if (cnt == len_qe) begin
`ifdef SEQ_SFP_EN
               state_n = SFP;
`else
               state_n = DONE;
`endif
            end else begin
               cnt_n = cnt_inc;
            end
         end
`ifdef SEQ_SFP_EN
         SFP: begin
            if (cnt == len_qe + CW'(1)) state_n = DONE;
            else                        cnt_n   = cnt_inc;
         end
`endif
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // output decode; SRAM data shows up one cycle after its address, so writes trail reads by one
      len_e = CW'(len_n);
      case (state_n)
         IDLE: busy_n = 1'b0;
         W_FILL: begin
            if (cnt_n < CW'(col)) begin
               inst_n[CEN_XMEM]                = 1'b0;
               inst_n[WEN_XMEM]                = 1'b1;
               inst_n[A_XMEM_LO +: addr_bw]    = w_n + addr_bw'(cnt_n);
            end
            if (cnt_n != '0) inst_n[L0_WR] = 1'b1;
         end
         W_LOAD: begin
            inst_n[L0_RD]     = 1'b1;
            inst_n[KLOAD_BIT] = 1'b1;
         end
         A_FILL: begin
            if (cnt_n < len_e) begin
               inst_n[CEN_XMEM]                = 1'b0;
               inst_n[WEN_XMEM]                = 1'b1;
               inst_n[A_XMEM_LO +: addr_bw]    = a_n + addr_bw'(cnt_n);
            end
            if (cnt_n != '0) inst_n[L0_WR] = 1'b1;
         end
         EXEC: begin
            inst_n[L0_RD]    = 1'b1;
            inst_n[EXEC_BIT] = 1'b1;
         end
         DRAIN: ;
         O_READ: begin
            if (cnt_n < len_e) inst_n[OFIFO_RD] = 1'b1;
            if (cnt_n != '0) begin
               inst_n[CEN_PMEM]             = 1'b0;
               inst_n[WEN_PMEM]             = 1'b0;
               inst_n[A_PMEM_LO +: addr_bw] = p_n + addr_bw'(cnt_n - CW'(1));
            end
         end
`ifdef SEQ_SFP_EN
         SFP: begin
            if (cnt_n < len_e) begin
               inst_n[CEN_PMEM]             = 1'b0;
               inst_n[WEN_PMEM]             = 1'b1;
               inst_n[A_PMEM_LO +: addr_bw] = p_n + addr_bw'(cnt_n);
            end
            if ((cnt_n != '0) && (cnt_n <= len_e)) inst_n[SFP_ACC] = 1'b1;
            if (cnt_n == len_e + CW'(1))            inst_n[SFP_RELU] = 1'b1;
         end
`endif
         DONE: begin
            busy_n = 1'b0;
            done_n = 1'b1;
         end
         default: busy_n = 1'b0;
      endcase
   end

   // state, phase counter, latched tile config and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         w_q   <= '0;
         a_q   <= '0;
         p_q   <= '0;
         len_q <= '0;
         inst  <= INST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         w_q   <= w_n;
         a_q   <= a_n;
         p_q   <= p_n;
         len_q <= len_n;
         inst  <= inst_n;
         busy  <= busy_n;
         done  <= done_n;
         err   <= err_n;
      end
   end

endmodule
